acc_cpu_core: RTL and testbench

//  8-bit accumulator CPU: fetch/decode/execute FSM, 256x8 single-port sync RAM, 4-bit-select combinational ALU.

---
 rtl/acc_cpu_core_if.sv | 26 ++
 rtl/acc_cpu_core.sv | 193 +++++++++++++++++++
 tb/tb_acc_cpu_core.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/acc_cpu_core_if.sv
// Host-side bundle of acc_cpu_core: run control, RAM host port and status.
interface acc_cpu_core_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  run;
   logic                  host_we;
   logic [ADDR_WIDTH-1:0] host_addr;
   logic [DATA_WIDTH-1:0] host_wdata;
   logic [DATA_WIDTH-1:0] host_rdata;
   logic [ADDR_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] ac;
   logic                  halted;

   // Host / bench side
   modport master (
      output run, host_we, host_addr, host_wdata,
      input  host_rdata, pc, ac, halted
   );

   // CPU side
   modport slave (
      input  run, host_we, host_addr, host_wdata,
      output host_rdata, pc, ac, halted
   );
endinterface

// File: rtl/acc_cpu_core.sv
// 8-bit accumulator CPU: multi-cycle fetch/decode/execute FSM, 256x8 sync RAM,
// combinational ALU. Host loads/reads RAM while the core sits in IDLE.
module acc_cpu_core #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   acc_cpu_core_if.slave  io_host
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned SEL_W = 4;

   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUBT  = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'h7;
   localparam logic [3:0] OP_SKIP  = 4'h8;
   localparam logic [3:0] OP_JUMP  = 4'h9;
   localparam logic [3:0] OP_CLEAR = 4'hA;

   // *W states cover the one-cycle RAM read latency.
   typedef enum logic [3:0] {
      S_IDLE, S_F1, S_F1W, S_F2, S_F2W, S_F3,
      S_EXEC, S_MEMW, S_MEMR, S_ALU, S_STORE
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [ADDR_WIDTH-1:0] r_mar;
   logic [DATA_WIDTH-1:0] r_ac;
   logic [DATA_WIDTH-1:0] r_mbr;
   logic [DATA_WIDTH-1:0] r_ir1;
   logic [DATA_WIDTH-1:0] r_ir2;
   logic                  r_halted;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic [3:0]            w_op;
   logic [SEL_W-1:0]      w_alu_sel;
   logic [DATA_WIDTH-1:0] w_alu_y;
   logic                  w_skip;
   state_t                w_after;
   logic                  w_host_own;
   logic [ADDR_WIDTH-1:0] w_ram_addr;
   logic [DATA_WIDTH-1:0] w_ram_wdata;
   logic                  w_ram_we;

   // Combinational ALU; results wrap modulo 2**DATA_WIDTH.
   function automatic logic [DATA_WIDTH-1:0] alu(
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b,
      input logic [SEL_W-1:0]      sel
   );
      logic [DATA_WIDTH-1:0] y;
      case (sel)
         4'b0000: y = b;
         4'b0001: y = a + b;
         4'b0010: y = a - b;
         4'b0011: y = a & b;
         4'b0100: y = a | b;
         4'b0101: y = a ^ b;
         4'b0110: y = ~a;
         4'b0111: y = a << 1;
         4'b1000: y = a >> 1;
         default: y = a;
      endcase
      return y;
   endfunction

   // Decode: ALU select, skip condition, state after a completed instruction.
   always_comb begin
      w_op      = r_ir1[DATA_WIDTH-1 -: 4];
      w_alu_sel = 4'b1111;
      w_skip    = 1'b0;
      case (w_op)
         OP_LOAD: w_alu_sel = 4'b0000;
         OP_ADD:  w_alu_sel = 4'b0001;
         OP_SUBT: w_alu_sel = 4'b0010;
         default: w_alu_sel = 4'b1111;
      endcase
      casez (r_ir1[3:0])
         4'b00??: w_skip = r_ac[DATA_WIDTH-1];
         4'b01??: w_skip = (r_ac == '0);
         4'b10??: w_skip = !r_ac[DATA_WIDTH-1] && (r_ac != '0);
         default: w_skip = 1'b0;
      endcase
      w_alu_y = alu(r_ac, r_mbr, w_alu_sel);
      w_after = io_host.run ? S_F1 : S_IDLE;
   end

   // RAM port mux: the host owns RAM only in IDLE so a stopped instruction
   // can still finish its fetch/operand access; host writes need run=0.
   always_comb begin
      w_host_own  = (r_state == S_IDLE);
      w_ram_addr  = w_host_own ? io_host.host_addr : r_mar;
      w_ram_wdata = w_host_own ? io_host.host_wdata : r_mbr;
      w_ram_we    = w_host_own ? (io_host.host_we && !io_host.run)
                               : ((r_state == S_STORE) && !rst);
   end

   // Single-port sync RAM, registered read, read-during-write returns old data.
   always_ff @(posedge clk) begin
      if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wdata;
      r_rdata <= r_mem[w_ram_addr];
   end

   // Control FSM and architectural registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_pc     <= '0;
         r_mar    <= '0;
         r_ac     <= '0;
         r_mbr    <= '0;
         r_ir1    <= '0;
         r_ir2    <= '0;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (io_host.run && !r_halted) r_state <= S_F1;
            S_F1: begin
               r_mar   <= r_pc;
               r_state <= S_F1W;
            end
            S_F1W: r_state <= S_F2;
            S_F2: begin
               r_ir1   <= r_rdata;
               r_pc    <= r_pc + ADDR_WIDTH'(1);
               r_mar   <= r_pc + ADDR_WIDTH'(1);
               r_state <= S_F2W;
            end
            S_F2W: r_state <= S_F3;
            S_F3: begin
               r_ir2   <= r_rdata;
               r_pc    <= r_pc + ADDR_WIDTH'(1);
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               case (w_op)
                  OP_LOAD, OP_ADD, OP_SUBT: begin
                     r_mar   <= ADDR_WIDTH'(r_ir2);
                     r_state <= S_MEMW;
                  end
                  OP_STORE: begin
                     r_mar   <= ADDR_WIDTH'(r_ir2);
                     r_mbr   <= r_ac;
                     r_state <= S_STORE;
                  end
                  OP_HALT: begin
                     r_pc     <= r_pc - ADDR_WIDTH'(2);
                     r_halted <= 1'b1;
                     r_state  <= S_IDLE;
                  end
                  OP_SKIP: begin
                     if (w_skip) r_pc <= r_pc + ADDR_WIDTH'(2);
                     r_state <= w_after;
                  end
                  OP_JUMP: begin
                     r_pc    <= ADDR_WIDTH'(r_ir2);
                     r_state <= w_after;
                  end
                  OP_CLEAR: begin
                     r_ac    <= '0;
                     r_state <= w_after;
                  end
                  default: r_state <= w_after;
               endcase
            end
            S_MEMW: r_state <= S_MEMR;
            S_MEMR: begin
               r_mbr   <= r_rdata;
               r_state <= S_ALU;
            end
            S_ALU: begin
               r_ac    <= w_alu_y;
               r_state <= w_after;
            end
            S_STORE: r_state <= w_after;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Status outputs are straight register taps.
   assign io_host.host_rdata = r_rdata;
   assign io_host.pc         = r_pc;
   assign io_host.ac         = r_ac;
   assign io_host.halted     = r_halted;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: host port, example program, ALU wrap,
// SKIPCOND variants, mid-program reset and PC wrap-around.
module tb_acc_cpu_core;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] rd;

   acc_cpu_core_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

   acc_cpu_core #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .io_host (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      bus.run = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic hw(input logic [7:0] a, input logic [7:0] d);
      bus.host_we    = 1'b1;
      bus.host_addr  = a;
      bus.host_wdata = d;
      tick();
      bus.host_we    = 1'b0;
   endtask

   task automatic hr(input logic [7:0] a, output logic [7:0] d);
      bus.host_addr = a;
      tick();
      d = bus.host_rdata;
   endtask

   // Run until HALT with a cycle budget; host_we is dropped together with run.
   task automatic run_prog(input string tag);
      int n;
      n = 0;
      bus.run = 1'b1;
      while (!bus.halted && n < 2000) begin
         tick();
         n++;
      end
      bus.host_we = 1'b0;
      bus.run     = 1'b0;
      check({tag, "_halted"}, 32'(bus.halted), 32'd1);
      tick();
   endtask

   task automatic load_main;
      hw(8'h00, 8'h11); hw(8'h01, 8'h10);
      hw(8'h02, 8'h31); hw(8'h03, 8'h11);
      hw(8'h04, 8'h21); hw(8'h05, 8'h12);
      hw(8'h06, 8'h70); hw(8'h07, 8'h00);
   endtask

   typedef struct {
      logic [7:0] m10;
      logic [7:0] cond;
      logic [7:0] pc;
   } skip_vec_t;

   skip_vec_t skv [7];

   initial begin
      bus.run = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      check("rst_pc", 32'(bus.pc), 32'h00);
      check("rst_ac", 32'(bus.ac), 32'h00);
      check("rst_halted", 32'(bus.halted), 32'd0);

      // Host write/read, read-during-write returns old data
      hw(8'h3C, 8'hA5);
      hr(8'h3C, rd);
      check("host_rd_a5", 32'(rd), 32'hA5);
      bus.host_addr = 8'h3C; bus.host_we = 1'b1; bus.host_wdata = 8'h5A;
      tick();
      bus.host_we = 1'b0;
      check("host_rdw_old", 32'(bus.host_rdata), 32'hA5);
      hr(8'h3C, rd);
      check("host_rd_5a", 32'(rd), 32'h5A);

      // Example program; host write attempted throughout the run
      load_main();
      hw(8'h10, 8'h05); hw(8'h11, 8'h07); hw(8'h30, 8'h33);
      bus.host_we = 1'b1; bus.host_addr = 8'h30; bus.host_wdata = 8'hEE;
      run_prog("main");
      check("main_ac", 32'(bus.ac), 32'h0C);
      check("main_pc", 32'(bus.pc), 32'h06);
      hr(8'h12, rd);
      check("main_m12", 32'(rd), 32'h0C);
      hr(8'h30, rd);
      check("run_wr_ignored", 32'(rd), 32'h33);

      // Reset clears halted
      do_reset();
      check("rst2_halted", 32'(bus.halted), 32'd0);
      check("rst2_pc", 32'(bus.pc), 32'h00);

      // Reset mid-program, then rerun from intact RAM
      hw(8'h12, 8'h00);
      bus.run = 1'b1;
      repeat (15) tick();
      check("mid_ac", 32'(bus.ac), 32'h05);
      check("mid_pc", 32'(bus.pc), 32'h04);
      do_reset();
      check("midrst_pc", 32'(bus.pc), 32'h00);
      check("midrst_ac", 32'(bus.ac), 32'h00);
      check("midrst_halted", 32'(bus.halted), 32'd0);
      hr(8'h02, rd);
      check("prog_intact", 32'(rd), 32'h31);
      run_prog("rerun");
      check("rerun_ac", 32'(bus.ac), 32'h0C);
      check("rerun_pc", 32'(bus.pc), 32'h06);
      hr(8'h12, rd);
      check("rerun_m12", 32'(rd), 32'h0C);

      // ADD wraps modulo 256
      do_reset();
      hw(8'h10, 8'hF0); hw(8'h11, 8'h20);
      run_prog("wrap");
      check("wrap_ac", 32'(bus.ac), 32'h10);
      hr(8'h12, rd);
      check("wrap_m12", 32'(rd), 32'h10);

      // SKIPCOND: LOAD 10; SKIP cond; JUMP 08; HALT@06; HALT@08
      skv[0] = '{8'h00, 8'h84, 8'h06};
      skv[1] = '{8'h05, 8'h84, 8'h08};
      skv[2] = '{8'h80, 8'h80, 8'h06};
      skv[3] = '{8'h05, 8'h80, 8'h08};
      skv[4] = '{8'h05, 8'h88, 8'h06};
      skv[5] = '{8'h80, 8'h88, 8'h08};
      skv[6] = '{8'h00, 8'h8C, 8'h08};
      for (int i = 0; i < 7; i++) begin
         do_reset();
         hw(8'h00, 8'h11); hw(8'h01, 8'h10);
         hw(8'h02, skv[i].cond); hw(8'h03, 8'h00);
         hw(8'h04, 8'h90); hw(8'h05, 8'h08);
         hw(8'h06, 8'h70); hw(8'h07, 8'h00);
         hw(8'h08, 8'h70); hw(8'h09, 8'h00);
         hw(8'h10, skv[i].m10);
         run_prog($sformatf("skip%0d", i));
         check($sformatf("skip%0d_pc", i), 32'(bus.pc), 32'(skv[i].pc));
      end

      // JUMP FE to LOAD at FE/FF: operand from FF, PC wraps to 00
      do_reset();
      hw(8'h00, 8'h84); hw(8'h01, 8'h00);
      hw(8'h02, 8'h70); hw(8'h03, 8'h00);
      hw(8'h04, 8'h90); hw(8'h05, 8'hFE);
      hw(8'hFE, 8'h11); hw(8'hFF, 8'h20);
      hw(8'h20, 8'h42);
      run_prog("pcwrap");
      check("pcwrap_ac", 32'(bus.ac), 32'h42);
      check("pcwrap_pc", 32'(bus.pc), 32'h02);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
